fsk_blink_transmitter: RTL and testbench



---
 rtl/fsk_blink_transmitter_pkg.sv | 40 ++++
 rtl/fsk_blink_transmitter_square_wave_gen.sv | 37 +++
 rtl/fsk_blink_transmitter.sv | 162 ++++++++++++++++
 tb/tb_fsk_blink_transmitter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsk_blink_transmitter_pkg.sv
// fsk_blink_transmitter_pkg
// Shared definitions for the FSK blink transmitter and for any frequency
// analyzer configuration that must agree with it on tone frequencies.
//   state_t       : transmitter FSM state encoding (IDLE, SYMBOL, GAP)
//   half_period() : clock cycles per half period of a square-wave tone
//   tones_legal() : parameter legality check shared by both ends of the link
package fsk_blink_transmitter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYMBOL = 2'd1,
        GAP    = 2'd2
    } state_t;

    // Integer division on purpose: a tone that does not divide the clock
    // evenly is rounded down, and both ends of the link use the same rounding.
    function automatic int unsigned half_period(input int unsigned clock_hz,
                                                input int unsigned tone_hz);
        if (tone_hz == 0) begin
            return 0;
        end
        return clock_hz / (2 * tone_hz);
    endfunction

    // A symbol must hold at least one full period of the slower tone,
    // otherwise the receiver cannot tell the two tones apart.
    function automatic bit tones_legal(input int unsigned clock_hz,
                                       input int unsigned freq0_hz,
                                       input int unsigned freq1_hz,
                                       input int unsigned symbol_cycles);
        longint unsigned h0;
        longint unsigned h1;
        longint unsigned hmax;
        h0   = longint'(half_period(clock_hz, freq0_hz));
        h1   = longint'(half_period(clock_hz, freq1_hz));
        hmax = (h0 > h1) ? h0 : h1;
        return (h0 >= 1) && (h1 >= 1) && (longint'(symbol_cycles) >= 2 * hmax);
    endfunction

endpackage

// File: rtl/fsk_blink_transmitter_square_wave_gen.sv
// square_wave_gen
// Toggle counter producing a square wave whose high and low phases each last
// half_period cycles. A restart forces the wave high with a fresh count, so
// the cycle after restart is the first high cycle of a new period.
//   clock       : system clock
//   reset       : synchronous, active-high reset (wave low)
//   restart     : start a new period, high phase first
//   half_period : cycles per half period; may change between restarts
//   wave        : square-wave output
module square_wave_gen (
    input  logic        clock,
    input  logic        reset,
    input  logic        restart,
    input  logic [31:0] half_period,
    output logic        wave
);

    logic [31:0] count;

    // The compare is written as count+1 >= half_period so that a shrinking
    // half_period or a zero value can never strand the counter past its limit.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= 32'd0;
            wave  <= 1'b0;
        end else if (restart) begin
            count <= 32'd0;
            wave  <= 1'b1;
        end else if (count + 32'd1 >= half_period) begin
            count <= 32'd0;
            wave  <= ~wave;
        end else begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/fsk_blink_transmitter.sv
// fsk_blink_transmitter
// Turns a parallel word into a blinking emitter drive, MSB first, one bit per
// symbol of SYMBOL_CYCLES clocks: a square wave at FREQUENCY0 for a 0 and at
// FREQUENCY1 for a 1, optionally followed by GAP_CYCLES forced-low cycles.
//   clock      : system clock
//   reset      : synchronous, active-high reset
//   enable     : 1 = run; 0 = abort a word in progress / refuse new words
//   data_in    : word to transmit, sampled only at acceptance
//   data_valid : data_in valid
//   data_ready : block can accept a word this cycle
//   tx_out     : emitter drive
//   busy       : word in progress
//   bit_index  : index of the bit being sent
//   done       : one-cycle pulse in the first IDLE cycle after a complete word
module fsk_blink_transmitter
    import fsk_blink_transmitter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned FREQUENCY0      = 5000,
    parameter int unsigned FREQUENCY1      = 10000,
    parameter int unsigned CLOCK_FREQUENCY = 100000000,
    parameter int unsigned SYMBOL_CYCLES   = 1000000,
    parameter int unsigned GAP_CYCLES      = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(DATA_WIDTH)-1:0] bit_index,
    output logic                          done
);

    localparam int          IDX_W       = $clog2(DATA_WIDTH);
    localparam logic [31:0] HALF0       = half_period(CLOCK_FREQUENCY, FREQUENCY0);
    localparam logic [31:0] HALF1       = half_period(CLOCK_FREQUENCY, FREQUENCY1);
    localparam logic [31:0] SYMBOL_LAST = SYMBOL_CYCLES - 1;
    localparam logic [31:0] GAP_LAST    = GAP_CYCLES - 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(DATA_WIDTH - 1);

    if (!tones_legal(CLOCK_FREQUENCY, FREQUENCY0, FREQUENCY1, SYMBOL_CYCLES)) begin : g_illegal_params
        $error("fsk_blink_transmitter: half periods must be >= 1 and SYMBOL_CYCLES >= 2*max(HALF0,HALF1)");
    end

    state_t                state;
    state_t                next_state;
    logic [31:0]           count;
    logic [DATA_WIDTH-1:0] shift;
    logic [IDX_W-1:0]      index_q;
    logic                  done_q;
    logic                  wave;
    logic [31:0]           half_sel;
    logic                  symbol_end;
    logic                  gap_end;
    logic                  last_bit;
    logic                  accept;
    logic                  advance;
    logic                  next_bit;
    logic                  finish_word;

    // One shared counter times both symbols and gaps; it restarts at every
    // phase boundary so each symbol begins phase-aligned high.
    assign symbol_end  = (state == SYMBOL) && (count == SYMBOL_LAST);
    assign gap_end     = (state == GAP) && (count == GAP_LAST);
    assign last_bit    = (index_q == '0);
    assign accept      = !reset && enable && data_valid && (state == IDLE);
    assign advance     = enable && ((symbol_end && (GAP_CYCLES == 0)) || gap_end);
    assign next_bit    = advance && !last_bit;
    assign finish_word = advance && last_bit;
    assign half_sel    = shift[DATA_WIDTH-1] ? HALF1 : HALF0;

    // The tone generator is restarted on the edge that enters a symbol, so
    // the first symbol cycle is already high with a zero half-period count.
    square_wave_gen u_wave (
        .clock       (clock),
        .reset       (reset),
        .restart     (accept || next_bit),
        .half_period (half_sel),
        .wave        (wave)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; dropping enable anywhere in a word abandons it.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = SYMBOL;
                end
            end
            SYMBOL: begin
                if (!enable) begin
                    next_state = IDLE;
                end else if (symbol_end) begin
                    if (GAP_CYCLES != 0) begin
                        next_state = GAP;
                    end else if (last_bit) begin
                        next_state = IDLE;
                    end else begin
                        next_state = SYMBOL;
                    end
                end
            end
            GAP: begin
                if (!enable) begin
                    next_state = IDLE;
                end else if (gap_end) begin
                    next_state = last_bit ? IDLE : SYMBOL;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: shift register, bit index, phase counter and the done flag,
    // which is registered so it lands on the first IDLE cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            count   <= 32'd0;
            shift   <= '0;
            index_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= finish_word;
            if (accept) begin
                shift   <= data_in;
                index_q <= IDX_MSB;
                count   <= 32'd0;
            end else if (next_bit) begin
                shift   <= shift << 1;
                index_q <= index_q - IDX_W'(1);
                count   <= 32'd0;
            end else if (symbol_end || (state == IDLE) || !enable) begin
                count <= 32'd0;
            end else begin
                count <= count + 32'd1;
            end
        end
    end

    // Outputs; data_ready is held low during reset so no word slips in.
    always_comb begin
        tx_out     = (state == SYMBOL) && wave;
        busy       = (state != IDLE);
        data_ready = !reset && enable && (state == IDLE);
        done       = done_q;
        bit_index  = index_q;
    end

endmodule

// File: tb/tb_fsk_blink_transmitter.sv
// tb_fsk_blink_transmitter
// Self-checking bench for fsk_blink_transmitter. Two instances share the
// clock and reset: one without gaps and one with 4-cycle gaps, both with a
// 1 kHz clock, 100/250 Hz tones (half periods 5 and 2) and 20-cycle symbols.
// Expected outputs come from a per-cycle arithmetic model of the waveform.
module tb_fsk_blink_transmitter;

    localparam int SYM = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic       en0 = 1'b0;
    logic       dv0 = 1'b0;
    logic [3:0] din0 = 4'h0;
    logic       ready0, tx0, busy0, done0;
    logic [1:0] idx0;

    logic       en4 = 1'b0;
    logic       dv4 = 1'b0;
    logic [3:0] din4 = 4'h0;
    logic       ready4, tx4, busy4, done4;
    logic [1:0] idx4;

    int         total = 0;
    int         bad = 0;
    bit         sel = 1'b0;
    logic [5:0] obs;

    fsk_blink_transmitter #(
        .DATA_WIDTH(4), .FREQUENCY0(100), .FREQUENCY1(250),
        .CLOCK_FREQUENCY(1000), .SYMBOL_CYCLES(20), .GAP_CYCLES(0)
    ) dut_nogap (
        .clock(clock), .reset(reset), .enable(en0), .data_in(din0),
        .data_valid(dv0), .data_ready(ready0), .tx_out(tx0), .busy(busy0),
        .bit_index(idx0), .done(done0)
    );

    fsk_blink_transmitter #(
        .DATA_WIDTH(4), .FREQUENCY0(100), .FREQUENCY1(250),
        .CLOCK_FREQUENCY(1000), .SYMBOL_CYCLES(20), .GAP_CYCLES(4)
    ) dut_gap (
        .clock(clock), .reset(reset), .enable(en4), .data_in(din4),
        .data_valid(dv4), .data_ready(ready4), .tx_out(tx4), .busy(busy4),
        .bit_index(idx4), .done(done4)
    );

    always #5 clock = ~clock;

    // Observation vector of the selected instance: {tx, busy, done, ready, idx}.
    always_comb begin
        obs = sel ? {tx4, busy4, done4, ready4, idx4} : {tx0, busy0, done0, ready0, idx0};
    end

    // Drives the inputs of the currently selected instance.
    task automatic drive(input bit valid, input logic [3:0] data, input bit en);
        if (sel) begin
            dv4 = valid; din4 = data; en4 = en;
        end else begin
            dv0 = valid; din0 = data; en0 = en;
        end
    endtask

    // Expected observation vector j cycles into a word (j=0 is the cycle after
    // acceptance). Bits go MSB first; within a symbol the wave is high for the
    // first half period, so the level is set by the parity of t/half.
    function automatic logic [5:0] exp_cycle(input logic [3:0] w, input int gap, input int j);
        int per, b, t, h;
        logic tx;
        logic [1:0] idx;
        per = SYM + gap;
        if (j >= 4 * per) begin
            return 6'b001100;
        end
        b = j / per;
        t = j % per;
        idx = 2'(3 - b);
        if (t >= SYM) begin
            tx = 1'b0;
        end else begin
            h  = w[3 - b] ? 2 : 5;
            tx = ((t / h) % 2) == 0;
        end
        return {tx, 1'b1, 1'b0, 1'b0, idx};
    endfunction

    // Reset holds every output low even with enable and data_valid high.
    task automatic test_reset;
        reset = 1'b1;
        en0 = 1'b1; en4 = 1'b1; dv0 = 1'b1; dv4 = 1'b1; din0 = 4'hF; din4 = 4'hF;
        repeat (3) @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            #1;
            total++;
            if (obs !== 6'b000000) begin
                bad++;
                $display("[TB] FAIL reset_outputs inst=%0d got=%b exp=%b", s, obs, 6'b000000);
            end
        end
        reset = 1'b0; dv0 = 1'b0; dv4 = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            #1;
            total++;
            if (obs !== 6'b000100) begin
                bad++;
                $display("[TB] FAIL ready_after_reset inst=%0d got=%b exp=%b", s, obs, 6'b000100);
            end
        end
    endtask

    // Sends n words (the first fixed, the rest random) and checks every cycle.
    task automatic test_words(input bit s, input int gap, input logic [3:0] first, input int n);
        logic [3:0] w;
        logic [5:0] exp;
        sel = s;
        for (int k = 0; k < n; k++) begin
            w = (k == 0) ? first : 4'($urandom);
            @(negedge clock);
            drive(1'b1, w, 1'b1);
            #1;
            total++;
            if (obs !== 6'b000100) begin
                bad++;
                $display("[TB] FAIL idle_before_word gap=%0d got=%b exp=%b", gap, obs, 6'b000100);
            end
            for (int j = 0; j <= 4 * (SYM + gap); j++) begin
                @(negedge clock);
                if (j == 0) drive(1'b0, ~w, 1'b1);
                #1;
                exp = exp_cycle(w, gap, j);
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("[TB] FAIL word gap=%0d w=%b j=%0d got=%b exp=%b", gap, w, j, obs, exp);
                end
            end
        end
    endtask

    // Second word waits on data_valid and is accepted in the done cycle.
    task automatic test_back_to_back;
        logic [3:0] w1, w2;
        logic [5:0] exp;
        sel = 1'b0;
        w1 = 4'($urandom);
        w2 = ~w1;
        @(negedge clock);
        drive(1'b1, w1, 1'b1);
        for (int j = 0; j <= 161; j++) begin
            @(negedge clock);
            if (j == 0)  drive(1'b1, w2, 1'b1);
            if (j == 81) drive(1'b0, 4'h0, 1'b1);
            #1;
            exp = (j <= 80) ? exp_cycle(w1, 0, j) : exp_cycle(w2, 0, j - 81);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("[TB] FAIL back_to_back j=%0d got=%b exp=%b", j, obs, exp);
            end
        end
    endtask

    // Dropping enable on cycle 30 abandons the word without a done pulse.
    task automatic test_abort;
        logic [3:0] w, w2;
        logic [5:0] exp;
        sel = 1'b0;
        w = 4'($urandom);
        w2 = 4'($urandom);
        @(negedge clock);
        drive(1'b1, w, 1'b1);
        for (int j = 0; j < 30; j++) begin
            @(negedge clock);
            if (j == 0) drive(1'b0, w, 1'b1);
            #1;
            exp = exp_cycle(w, 0, j);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("[TB] FAIL abort_prefix j=%0d got=%b exp=%b", j, obs, exp);
            end
        end
        drive(1'b1, w2, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            #1;
            total++;
            if (obs[5:2] !== 4'b0000) begin
                bad++;
                $display("[TB] FAIL abort_idle k=%0d got=%b exp=%b", k, obs[5:2], 4'b0000);
            end
        end
        drive(1'b1, w2, 1'b1);
        #1;
        total++;
        if (obs[2] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ready_after_enable got=%b exp=1", obs[2]);
        end
        for (int j = 0; j <= 80; j++) begin
            @(negedge clock);
            if (j == 0) drive(1'b0, 4'h0, 1'b1);
            #1;
            exp = exp_cycle(w2, 0, j);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("[TB] FAIL after_abort j=%0d got=%b exp=%b", j, obs, exp);
            end
        end
    endtask

    // Reset mid-symbol wins over a simultaneous data_valid.
    task automatic test_reset_mid;
        logic [3:0] w;
        logic [5:0] exp;
        sel = 1'b1;
        w = 4'($urandom);
        @(negedge clock);
        drive(1'b1, w, 1'b1);
        for (int j = 0; j < 10; j++) begin
            @(negedge clock);
            if (j == 0) drive(1'b0, w, 1'b1);
            #1;
            exp = exp_cycle(w, 4, j);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("[TB] FAIL reset_mid_prefix j=%0d got=%b exp=%b", j, obs, exp);
            end
        end
        reset = 1'b1;
        drive(1'b1, ~w, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            #1;
            total++;
            if (obs !== 6'b000000) begin
                bad++;
                $display("[TB] FAIL reset_mid k=%0d got=%b exp=%b", k, obs, 6'b000000);
            end
        end
        reset = 1'b0;
        drive(1'b0, 4'h0, 1'b1);
        #1;
        total++;
        if (obs !== 6'b000100) begin
            bad++;
            $display("[TB] FAIL ready_after_reset_mid got=%b exp=%b", obs, 6'b000100);
        end
        @(negedge clock);
        #1;
        total++;
        if (obs !== 6'b000100) begin
            bad++;
            $display("[TB] FAIL not_accepted_in_reset got=%b exp=%b", obs, 6'b000100);
        end
    endtask

    initial begin
        test_reset();
        test_words(1'b0, 0, 4'b1010, 4);
        test_words(1'b1, 4, 4'b0001, 3);
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
